// File: rtl/switch_allocator_rr.sv
// switch_allocator_rr
// Switch allocator between the input buffers and the crossbar. Each
// (outport, VC) entry is arbitrated independently. A won entry is held as a
// registered crossbar select/enable until the owning buffer drops buf_valid.
// Build option: define SWITCH_ALLOCATOR_RR_EN for round-robin arbitration
// with a pointer per entry. Leave it undefined for fixed priority, where the
// lowest buffer index wins.

module switch_allocator_rr #(
  parameter int NUM_BUFFERS  = 4,
  parameter int NUM_OUTPORTS = 4,
  parameter int NUM_VCS      = 2,
  localparam int SEL_W = $clog2(NUM_BUFFERS) + ((NUM_BUFFERS == 1) ? 1 : 0),
  localparam int OUT_W = $clog2(NUM_OUTPORTS) + ((NUM_OUTPORTS == 1) ? 1 : 0),
  localparam int VC_W  = $clog2(NUM_VCS) + ((NUM_VCS == 1) ? 1 : 0)
) (
  input  logic                                            clk,
  input  logic                                            n_rst,
  input  logic [NUM_BUFFERS-1:0]                          req_valid,
  input  logic [NUM_BUFFERS-1:0][OUT_W-1:0]               req_outport,
  input  logic [NUM_BUFFERS-1:0][VC_W-1:0]                req_vc,
  input  logic [NUM_BUFFERS-1:0]                          buf_valid,
  output logic [NUM_BUFFERS-1:0]                          grant,
  output logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][SEL_W-1:0] select,
  output logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]            enable
);

  logic [NUM_BUFFERS-1:0]                              owns;
  logic [NUM_BUFFERS-1:0]                              eligible;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][NUM_BUFFERS-1:0] cand;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][NUM_BUFFERS-1:0] pick;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]                win_valid;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][SEL_W-1:0]     win_sel;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]                next_enable;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][SEL_W-1:0]     next_select;

  // Flag every buffer that currently owns an enabled entry
  always_comb begin
    owns = '0;
    for (int b = 0; b < NUM_BUFFERS; b++) begin
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
        for (int v = 0; v < NUM_VCS; v++) begin
          if (enable[o][v] && (select[o][v] == SEL_W'(b))) begin
            owns[b] = 1'b1;
          end
        end
      end
    end
  end

  // A request is eligible only if it is in range, its buffer is active and the buffer owns nothing yet
  always_comb begin
    eligible = '0;
    for (int b = 0; b < NUM_BUFFERS; b++) begin
      eligible[b] = req_valid[b] && buf_valid[b] && !owns[b] &&
                    (int'(req_outport[b]) < NUM_OUTPORTS) &&
                    (int'(req_vc[b]) < NUM_VCS);
    end
  end

  // Candidate vector per free entry: the eligible buffers that target it
  always_comb begin
    cand = '0;
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        for (int b = 0; b < NUM_BUFFERS; b++) begin
          cand[o][v][b] = !enable[o][v] && eligible[b] &&
                          (int'(req_outport[b]) == o) && (int'(req_vc[b]) == v);
        end
      end
    end
  end

`ifdef SWITCH_ALLOCATOR_RR_EN
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][SEL_W-1:0]       rr_ptr;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][NUM_BUFFERS-1:0] upper;

  // Candidates at or above the pointer take precedence, which gives the wrap-around search order
  always_comb begin
    upper = '0;
    pick  = '0;
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        for (int b = 0; b < NUM_BUFFERS; b++) begin
          upper[o][v][b] = cand[o][v][b] && (int'(rr_ptr[o][v]) <= b);
        end
        pick[o][v] = (|upper[o][v]) ? upper[o][v] : cand[o][v];
      end
    end
  end

  // Pointer moves one past the winner and holds while the entry is not granted
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rr_ptr <= '0;
    end else begin
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
        for (int v = 0; v < NUM_VCS; v++) begin
          if (win_valid[o][v]) begin
            rr_ptr[o][v] <= SEL_W'((int'(win_sel[o][v]) + 1) % NUM_BUFFERS);
          end
        end
      end
    end
  end
`else
  // Fixed priority: every candidate competes and the lowest index wins below
  always_comb begin
    pick = cand;
  end
`endif

  // Lowest set bit of the pick vector is the winner of each entry
  always_comb begin
    win_valid = '0;
    win_sel   = '0;
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        for (int b = NUM_BUFFERS - 1; b >= 0; b--) begin
          if (pick[o][v][b]) begin
            win_valid[o][v] = 1'b1;
            win_sel[o][v]   = SEL_W'(b);
          end
        end
      end
    end
  end

  // Grant pulses to winners. It is held low while reset is asserted.
  always_comb begin
    grant = '0;
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        for (int b = 0; b < NUM_BUFFERS; b++) begin
          if (win_valid[o][v] && (win_sel[o][v] == SEL_W'(b))) begin
            grant[b] = 1'b1;
          end
        end
      end
    end
    grant = grant & {NUM_BUFFERS{n_rst}};
  end

  // Busy entries release when their owner drops buf_valid. Free entries take the new winner.
  always_comb begin
    next_enable = enable;
    next_select = select;
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (enable[o][v]) begin
          for (int b = 0; b < NUM_BUFFERS; b++) begin
            if ((select[o][v] == SEL_W'(b)) && !buf_valid[b]) begin
              next_enable[o][v] = 1'b0;
            end
          end
        end else if (win_valid[o][v]) begin
          next_enable[o][v] = 1'b1;
          next_select[o][v] = win_sel[o][v];
        end
      end
    end
  end

  // Registered crossbar configuration
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      enable <= '0;
      select <= '0;
    end else begin
      enable <= next_enable;
      select <= next_select;
    end
  end

endmodule

// File: tb/tb_switch_allocator_rr.sv
// tb_switch_allocator_rr
// Self-checking bench for switch_allocator_rr. It uses three outports so that an
// out-of-range outport value can be driven. The reference model tracks
// owner, enable and pointer per entry. It follows SWITCH_ALLOCATOR_RR_EN the
// same way as the design.

module tb_switch_allocator_rr;

  localparam int NB    = 4;
  localparam int NO    = 3;
  localparam int NV    = 2;
  localparam int SEL_W = 2;
  localparam int OUT_W = 2;
  localparam int VC_W  = 1;
`ifdef SWITCH_ALLOCATOR_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef logic [NO-1:0][NV-1:0]            en_t;
  typedef logic [NO-1:0][NV-1:0][SEL_W-1:0] sel_t;

  logic                        clk;
  logic                        n_rst;
  logic [NB-1:0]               req_valid;
  logic [NB-1:0][OUT_W-1:0]    req_outport;
  logic [NB-1:0][VC_W-1:0]     req_vc;
  logic [NB-1:0]               buf_valid;
  logic [NB-1:0]               grant;
  sel_t                        select;
  en_t                         enable;

  int n_tests = 0;
  int n_fail  = 0;

  bit            m_en  [NO][NV];
  int            m_sel [NO][NV];
  int            m_ptr [NO][NV];
  bit            x_en  [NO][NV];
  int            x_sel [NO][NV];
  int            x_ptr [NO][NV];
  logic [NB-1:0] exp_grant;

  switch_allocator_rr #(
    .NUM_BUFFERS (NB),
    .NUM_OUTPORTS(NO),
    .NUM_VCS     (NV)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .req_valid  (req_valid),
    .req_outport(req_outport),
    .req_vc     (req_vc),
    .buf_valid  (buf_valid),
    .grant      (grant),
    .select     (select),
    .enable     (enable)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int o = 0; o < NO; o++) begin
      for (int v = 0; v < NV; v++) begin
        m_en[o][v] = 0; m_sel[o][v] = 0; m_ptr[o][v] = 0;
        x_en[o][v] = 0; x_sel[o][v] = 0; x_ptr[o][v] = 0;
      end
    end
    exp_grant = '0;
  endtask

  // Expected grants and next state from the current inputs
  task automatic model_eval();
    bit owned [NB];
    int best, bestd, d;
    exp_grant = '0;
    for (int b = 0; b < NB; b++) owned[b] = 0;
    for (int o = 0; o < NO; o++)
      for (int v = 0; v < NV; v++)
        if (m_en[o][v]) owned[m_sel[o][v]] = 1;
    for (int o = 0; o < NO; o++) begin
      for (int v = 0; v < NV; v++) begin
        x_en[o][v] = m_en[o][v]; x_sel[o][v] = m_sel[o][v]; x_ptr[o][v] = m_ptr[o][v];
        if (m_en[o][v]) begin
          if (buf_valid[m_sel[o][v]] == 1'b0) x_en[o][v] = 0;
        end else begin
          best = -1; bestd = NB;
          for (int b = 0; b < NB; b++) begin
            if (req_valid[b] && buf_valid[b] && !owned[b] &&
                int'(req_outport[b]) == o && int'(req_vc[b]) == v) begin
              d = RR ? (b - m_ptr[o][v] + NB) % NB : b;
              if (d < bestd) begin bestd = d; best = b; end
            end
          end
          if (best >= 0) begin
            exp_grant[best] = 1'b1;
            x_en[o][v] = 1; x_sel[o][v] = best; x_ptr[o][v] = (best + 1) % NB;
          end
        end
      end
    end
  endtask

  task automatic model_commit();
    for (int o = 0; o < NO; o++)
      for (int v = 0; v < NV; v++) begin
        m_en[o][v] = x_en[o][v]; m_sel[o][v] = x_sel[o][v]; m_ptr[o][v] = x_ptr[o][v];
      end
  endtask

  function automatic en_t model_enable();
    en_t e = '0;
    for (int o = 0; o < NO; o++)
      for (int v = 0; v < NV; v++) e[o][v] = m_en[o][v];
    return e;
  endfunction

  function automatic sel_t model_select();
    sel_t s = '0;
    for (int o = 0; o < NO; o++)
      for (int v = 0; v < NV; v++) s[o][v] = SEL_W'(m_sel[o][v]);
    return s;
  endfunction

  task automatic drive_idle();
    req_valid = '0; req_outport = '0; req_vc = '0; buf_valid = '1;
  endtask

  task automatic set_req(input int b, input int o, input int v);
    req_valid[b] = 1'b1; req_outport[b] = OUT_W'(o); req_vc[b] = VC_W'(v);
  endtask

  // Wait for the sampling point in the middle of the current cycle
  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  // Advance one clock edge and move the model along with it
  task automatic tick();
    model_eval();
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    drive_idle();
    model_reset();
    #2;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    drive_idle();
    #1;
    n_rst = 1'b0;
    set_req(0, 0, 0);
    set_req(2, 1, 1);
    #2;
    n_tests++;
    if (grant !== '0) begin n_fail++; $display("[TB] FAIL reset_grant: got %b expected 0", grant); end
    n_tests++;
    if (enable !== '0) begin n_fail++; $display("[TB] FAIL reset_enable: got %b expected 0", enable); end
    n_tests++;
    if (select !== '0) begin n_fail++; $display("[TB] FAIL reset_select: got %h expected 0", select); end
    @(posedge clk);
    #1;
    n_tests++;
    if (enable !== '0 || grant !== '0) begin
      n_fail++; $display("[TB] FAIL reset_held: enable %b grant %b expected both 0", enable, grant);
    end
    do_reset();
  endtask

  task automatic test_single_grant();
    set_req(1, 2, 1);
    settle();
    n_tests++;
    if (grant !== 4'b0010) begin n_fail++; $display("[TB] FAIL single_grant: got %b expected 0010", grant); end
    tick();
    req_valid = '0;
    settle();
    n_tests++;
    if (enable[2][1] !== 1'b1 || select[2][1] !== 2'd1) begin
      n_fail++; $display("[TB] FAIL single_entry: enable %b select %0d expected 1 and 1", enable[2][1], select[2][1]);
    end
    tick();
    buf_valid[1] = 1'b0;
    tick();
    buf_valid = '1;
    settle();
    n_tests++;
    if (enable[2][1] !== 1'b0) begin n_fail++; $display("[TB] FAIL single_release: got %b expected 0", enable[2][1]); end
    tick();
  endtask

  task automatic test_rr_pair();
    int w;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(0, 0, 0);
      set_req(3, 0, 0);
      buf_valid = '1;
      settle();
      w = (RR && (i % 2 == 1)) ? 3 : 0;
      n_tests++;
      if (grant !== NB'(1 << w)) begin
        n_fail++; $display("[TB] FAIL rr_pair_%0d: got %b expected %b", i, grant, NB'(1 << w));
      end
      tick();
      req_valid[w] = 1'b0;
      buf_valid[w] = 1'b0;
      settle();
      n_tests++;
      if (grant !== '0 || enable[0][0] !== 1'b1) begin
        n_fail++; $display("[TB] FAIL rr_hold_%0d: grant %b enable %b expected 0000 and 1", i, grant, enable[0][0]);
      end
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_parallel();
    en_t e;
    set_req(0, 0, 0);
    set_req(1, 1, 0);
    set_req(2, 2, 1);
    settle();
    n_tests++;
    if (grant !== 4'b0111) begin n_fail++; $display("[TB] FAIL parallel_grant: got %b expected 0111", grant); end
    tick();
    req_valid = '0;
    settle();
    e = '0; e[0][0] = 1'b1; e[1][0] = 1'b1; e[2][1] = 1'b1;
    n_tests++;
    if (enable !== e) begin n_fail++; $display("[TB] FAIL parallel_enable: got %b expected %b", enable, e); end
    n_tests++;
    if (select[2][1] !== 2'd2 || select[1][0] !== 2'd1) begin
      n_fail++; $display("[TB] FAIL parallel_select: got %0d %0d expected 2 1", select[2][1], select[1][0]);
    end
    buf_valid = '0;
    tick();
    buf_valid = '1;
    tick();
  endtask

  task automatic test_release_and_request();
    set_req(0, 1, 1);
    tick();
    req_valid = '0;
    buf_valid[0] = 1'b0;
    set_req(2, 1, 1);
    settle();
    n_tests++;
    if (grant !== '0) begin n_fail++; $display("[TB] FAIL release_same_cycle: got %b expected 0000", grant); end
    tick();
    settle();
    n_tests++;
    if (enable[1][1] !== 1'b0 || grant !== 4'b0100) begin
      n_fail++; $display("[TB] FAIL release_regrant: enable %b grant %b expected 0 and 0100", enable[1][1], grant);
    end
    tick();
    req_valid = '0;
    buf_valid = '1;
    settle();
    n_tests++;
    if (select[1][1] !== 2'd2 || enable[1][1] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL release_new_owner: select %0d enable %b expected 2 and 1", select[1][1], enable[1][1]);
    end
    buf_valid[2] = 1'b0;
    tick();
    buf_valid = '1;
    tick();
  endtask

  task automatic test_ignored();
    en_t e;
    set_req(1, 0, 1);
    tick();
    req_valid = '0;
    set_req(0, 3, 0);
    set_req(1, 2, 0);
    set_req(2, 1, 0);
    buf_valid[2] = 1'b0;
    settle();
    n_tests++;
    if (grant !== '0) begin n_fail++; $display("[TB] FAIL ignored_grant: got %b expected 0000", grant); end
    tick();
    settle();
    e = '0; e[0][1] = 1'b1;
    n_tests++;
    if (enable !== e) begin n_fail++; $display("[TB] FAIL ignored_enable: got %b expected %b", enable, e); end
    drive_idle();
    buf_valid[1] = 1'b0;
    tick();
    buf_valid = '1;
    tick();
  endtask

  task automatic test_reset_mid();
    en_t e;
    set_req(0, 0, 0);
    set_req(1, 1, 1);
    set_req(2, 2, 0);
    tick();
    req_valid = '0;
    settle();
    e = '0; e[0][0] = 1'b1; e[1][1] = 1'b1; e[2][0] = 1'b1;
    n_tests++;
    if (enable !== e) begin n_fail++; $display("[TB] FAIL mid_setup: got %b expected %b", enable, e); end
    @(posedge clk);
    #1;
    set_req(3, 0, 1);
    #2;
    n_rst = 1'b0;
    #1;
    n_tests++;
    if (enable !== '0 || select !== '0) begin
      n_fail++; $display("[TB] FAIL mid_reset_clear: enable %b select %h expected 0 and 0", enable, select);
    end
    n_tests++;
    if (grant !== '0) begin n_fail++; $display("[TB] FAIL mid_reset_grant: got %b expected 0000", grant); end
    @(posedge clk);
    #1;
    n_tests++;
    if (grant !== '0 || enable !== '0) begin
      n_fail++; $display("[TB] FAIL mid_reset_held: grant %b enable %b expected 0", grant, enable);
    end
    drive_idle();
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < NB; b++) begin
        req_valid[b]   = 1'($urandom_range(0, 1));
        req_outport[b] = OUT_W'($urandom_range(0, 3));
        req_vc[b]      = VC_W'($urandom_range(0, 1));
        buf_valid[b]   = ($urandom_range(0, 3) != 0);
      end
      settle();
      n_tests++;
      if (grant !== exp_grant) begin
        n_fail++; $display("[TB] FAIL random_grant c%0d: got %b expected %b", c, grant, exp_grant);
      end
      n_tests++;
      if (enable !== model_enable()) begin
        n_fail++; $display("[TB] FAIL random_enable c%0d: got %b expected %b", c, enable, model_enable());
      end
      n_tests++;
      if (select !== model_select()) begin
        n_fail++; $display("[TB] FAIL random_select c%0d: got %h expected %h", c, select, model_select());
      end
      tick();
    end
    drive_idle();
  endtask

  // Scenario sequence and summary
  initial begin
    n_rst = 1'b1;
    drive_idle();
    model_reset();
    test_reset();
    test_single_grant();
    test_rr_pair();
    test_parallel();
    test_release_and_request();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_allocator_rr.md
# switch_allocator_rr

Multi-requestor switch allocator for the chiplet switch, sitting between the input buffers and the crossbar. Every cycle it accepts allocation requests from all input buffers in parallel and arbitrates each (outport, VC) pair independently, round-robin among contending buffers. It holds each grant as a crossbar select/enable until the owning buffer drops `buf_valid`. Up to NUM_OUTPORTS×NUM_VCS allocations can be made in one cycle.

## Interface
Parameters:
- NUM_BUFFERS, 4, number of input buffers (requestors)
- NUM_OUTPORTS, 4, number of switch output ports
- NUM_VCS, 2, virtual channels per outport
- Derived: SEL_W = $clog2(NUM_BUFFERS) + (NUM_BUFFERS==1); OUT_W = $clog2(NUM_OUTPORTS) + (NUM_OUTPORTS==1); VC_W = $clog2(NUM_VCS) + (NUM_VCS==1)

Ports (clk, n_rst: one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- req_valid  in  [NUM_BUFFERS]  buffer b requests an allocation
- req_outport  in  [NUM_BUFFERS][OUT_W]  requested outport per buffer
- req_vc  in  [NUM_BUFFERS][VC_W]  requested VC per buffer
- buf_valid  in  [NUM_BUFFERS]  buffer still has an active packet; low releases its allocation
- grant  out  [NUM_BUFFERS]  combinational one-cycle grant pulse to buffer b
- select  out  [NUM_OUTPORTS][NUM_VCS][SEL_W]  registered crossbar source per (outport, VC)
- enable  out  [NUM_OUTPORTS][NUM_VCS]  registered allocation-active flag per (outport, VC)

## Operation
- Eligible request from b: req_valid[b]=1, buf_valid[b]=1, req_outport[b] < NUM_OUTPORTS, req_vc[b] < NUM_VCS, and b does not currently own any enabled entry. All other requests are ignored with no grant.
- For each (o,v) with enable[o][v]=0: the candidates are the eligible buffers targeting (o,v). One winner is chosen per arbitration rule (see Configuration). The winner gets grant=1 this cycle, and next_select[o][v]=winner, next_enable[o][v]=1.
- Entries with enable=1 accept no new allocation.
- Each buffer requests exactly one (o,v), so at most one grant per buffer per cycle.
- Release: next_enable[o][v] is cleared when buf_valid[select[o][v]]=0, evaluated on the current registered select/enable.
- select keeps its last value after release. It is only meaningful while enable=1.
- Round-robin pointer per (o,v), SEL_W bits. On a grant to b, the pointer becomes (b+1) mod NUM_BUFFERS. The search starts at the pointer index and wraps past NUM_BUFFERS-1 to 0. The pointer is unchanged when there is no grant.
- Handshake: a buffer holds req_valid with stable outport/VC until grant. Dropping the request before grant is legal and leaves no state behind.

## Timing
- Reset (n_rst=0, async): select=0, enable=0, all RR pointers=0, grant forced 0.
- Request in cycle t, uncontended and entry free: grant=1 in t; enable/select updated at the edge ending t and visible in t+1.
- buf_valid low in cycle t: enable=0 visible in t+1. A new request to that entry can be granted in t+1 and is enabled in t+2.
- Release and new request in the same cycle t for the same entry: no grant in t, because enable is still 1.
- Contention: N eligible buffers on one entry are each served within N allocations, and no buffer is starved.
- Reset mid-allocation clears all entries immediately. Buffers must re-request after reset.

## Configuration
- SWITCH_ALLOCATOR_RR_EN defined: round-robin arbitration with per-(o,v) pointers as above.
- SWITCH_ALLOCATOR_RR_EN undefined: fixed priority, lowest buffer index wins. Pointer registers are not built. All other behaviour is identical.

## Test plan
- Reset, then buffer 1 requests (o=2,v=1) with buf_valid=1 -> grant[1]=1 same cycle; next cycle enable[2][1]=1, select[2][1]=1.
- Buffers 0 and 3 both request (o=0,v=0) repeatedly, RR_EN defined -> grants go 0, 3, 0, 3 across successive allocations. RR_EN undefined -> always 0.
- Buffers 0, 1, 2 request (0,0), (1,0), (2,1) in the same cycle -> all three grant the same cycle; three entries enabled next cycle.
- Owner of (1,1) drops buf_valid in cycle t while buffer 2 requests (1,1) -> no grant in t; enable=0 in t+1 and grant[2]=1 in t+1; select[1][1]=2 in t+2.
- Request with outport=NUM_OUTPORTS, or from a buffer already owning an entry, or with buf_valid=0 -> no grant; enable unchanged.
- n_rst asserted while 3 entries are enabled -> enable=0, select=0 immediately; grant=0 while reset is held.
